snake_step_ctrl: RTL
====================

Name: snake_step_ctrl

Overview:
- Per-move sequencer for the snake body store (snake_body).
- On each game tick it:
  - latches the requested direction;
  - computes the next head;
  - checks wall and self collision by scanning body segments through the store's read port;
  - commits a push (with or without grow) to the store.
- Sits between the game-tick divider/input decoder and snake_body.
- Drives head, length and game-over status to the renderer.

Parameters:
- GRID_W, 40, playfield width in cells
- GRID_H, 30, playfield height in cells
- COORD_W, 6, bits per coordinate
- MAX_LEN, 64, body store capacity in segments
- LEN_W, 7, length counter width (holds 0..MAX_LEN)
- INIT_LEN, 3, length after reset/restart

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle move strobe
- restart  in  1  synchronous restart request
- dir_in  in  2  requested direction: 0 up, 1 right, 2 down, 3 left
- dir_valid  in  1  dir_in qualifier
- food_x  in  COORD_W  food cell x
- food_y  in  COORD_W  food cell y
- seg_idx  out  LEN_W  body read index (0 = head)
- seg_x  in  COORD_W  segment x, valid 1 cycle after seg_idx
- seg_y  in  COORD_W  segment y, valid 1 cycle after seg_idx
- push  out  1  one-cycle commit of new head to body store
- push_x  out  COORD_W  new head x, valid with push
- push_y  out  COORD_W  new head y, valid with push
- grow  out  1  with push: keep tail (length+1)
- body_clr  out  1  one-cycle pulse: body store reinitialises to INIT_LEN
- head_x  out  COORD_W  current head x
- head_y  out  COORD_W  current head y
- length  out  LEN_W  current length
- food_eaten  out  1  one-cycle pulse on food hit
- game_over  out  1  sticky until restart/reset
- busy  out  1  high from CALC through COMMIT

Behaviour:
Reset state (rst_n low):
- head = (GRID_W/2, GRID_H/2); dir = right; pend_dir = right; length = INIT_LEN.
- push, grow, body_clr, food_eaten, game_over, busy = 0; seg_idx = 0; state IDLE.

Direction latch:
- dir_valid captures dir_in into pend_dir any cycle.
- A capture equal to dir XOR 2 (reversal) is ignored.
- Last accepted value wins.

FSM states: IDLE, CALC, SCAN, COMMIT, OVER.
- IDLE
  - tick -> CALC; dir <= pend_dir.
  - tick in any other state is dropped.
- CALC (1 cycle)
  - nxt = head + step(dir).
  - Out of range (x<0, x>=GRID_W, y<0, y>=GRID_H) -> OVER.
  - eat = (nxt == food).
  - Scan limit L: length-1 if eat=0 (tail vacates), else length.
  - seg_idx <= 0.
  - -> SCAN.
- SCAN
  - Issues seg_idx 0..L-1, one per cycle; compares the returned segment one cycle later (pipelined).
  - Any match -> OVER immediately (remaining reads abandoned).
  - Last compare clear -> COMMIT.
  - Duration L+1 cycles.
- COMMIT (1 cycle)
  - push = 1; push_x/y = nxt; head <= nxt.
  - grow = eat && length < MAX_LEN; length increments when grow.
  - food_eaten = eat, even at MAX_LEN.
  - -> IDLE.
- OVER
  - game_over = 1; no pushes; ticks ignored.

Latency:
- tick to push = L+3 cycles.
- Example: length 3, no food -> push 5 cycles after tick.

Restart:
- Any state, including mid-SCAN: next cycle returns to reset values and pulses body_clr for 1 cycle.
- Restart has priority over a simultaneous tick.

Arithmetic:
- Coordinates are unsigned COORD_W.
- Bounds checked via COORD_W+1 signed step before truncation; no silent wrap.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined: crossing an edge wraps instead of ending the game:
  - x = -1 -> GRID_W-1; x = GRID_W -> 0; same for y.
  - Only self-collision causes OVER.
- Undefined: edge crossing -> OVER, as above.

Decomposition:
- Shared include snake_defs.vh holds:
  - direction codes DIR_UP/RIGHT/DOWN/LEFT;
  - FSM state encodings;
  - GRID_W/GRID_H/COORD_W/MAX_LEN defaults.
- Sub-module snake_next_head (combinational step + bound/wrap logic, holds the SNAKE_WRAP_EN switch) is natural.
- Direction latch and scan counter stay in the top.

Test Plan:
- Reset, length 3, head (20,15), dir right, food (30,30), one tick -> push 5 cycles later, push=(21,15), grow=0, length 3.
- Food at (21,15), tick -> push=(21,15), grow=1, food_eaten pulse, length 4.
- Head (20,15) dir right, dir_in=left with dir_valid -> ignored; next tick pushes (21,15).
- Head (39,15) dir right, tick:
  - without macro -> game_over=1, no push, later ticks ignored;
  - with SNAKE_WRAP_EN -> push=(0,15).
- Body returns a segment equal to the computed next head at index 2 -> OVER after that compare, no push; restart -> body_clr pulse, head (20,15), length 3, game_over=0.
- Length = MAX_LEN, food hit -> food_eaten=1, grow=0, length stays 64.

Source files
------------

// File: rtl/snake_step_ctrl_pkg.sv
// Shared types and defaults for the snake move sequencer.
// Direction codes, FSM states and grid/body size defaults.
package snake_step_ctrl_pkg;

  localparam int GRID_W_D   = 40;
  localparam int GRID_H_D   = 30;
  localparam int COORD_W_D  = 6;
  localparam int MAX_LEN_D  = 64;
  localparam int LEN_W_D    = 7;
  localparam int INIT_LEN_D = 3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  // Opposite directions differ only in bit 1.
  function automatic logic is_reverse(input dir_e req,
                                      input dir_e cur);
    return req == dir_e'(cur ^ 2'd2);
  endfunction

endpackage

// File: rtl/snake_step_ctrl_if.sv
// Link between the move sequencer and the snake body store:
// segment read port plus push/grow/clear commit signals.
interface snake_step_ctrl_if #(
  parameter int COORD_W = 6,
  parameter int LEN_W   = 7
);

  logic [LEN_W-1:0]   seg_idx;
  logic [COORD_W-1:0] seg_x;
  logic [COORD_W-1:0] seg_y;
  logic               push;
  logic [COORD_W-1:0] push_x;
  logic [COORD_W-1:0] push_y;
  logic               grow;
  logic               body_clr;

  modport master (
    output seg_idx,
    input  seg_x,
    input  seg_y,
    output push,
    output push_x,
    output push_y,
    output grow,
    output body_clr
  );

  modport slave (
    input  seg_idx,
    output seg_x,
    output seg_y,
    input  push,
    input  push_x,
    input  push_y,
    input  grow,
    input  body_clr
  );

endinterface

// File: rtl/snake_next_head.sv
// Next-head step with edge handling; SNAKE_WRAP_EN makes the
// playfield toroidal, otherwise leaving it flags oob.
module snake_next_head
  import snake_step_ctrl_pkg::*;
#(
  parameter int GRID_W  = GRID_W_D,
  parameter int GRID_H  = GRID_H_D,
  parameter int COORD_W = COORD_W_D
)(
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  dir_e               dir,
  output logic [COORD_W-1:0] nxt_x,
  output logic [COORD_W-1:0] nxt_y,
  output logic               oob
);

  localparam logic signed [COORD_W:0] ONE =
    (COORD_W+1)'(1);
  localparam logic signed [COORD_W:0] GW =
    (COORD_W+1)'(GRID_W);
  localparam logic signed [COORD_W:0] GH =
    (COORD_W+1)'(GRID_H);

  logic signed [COORD_W:0] sx;
  logic signed [COORD_W:0] sy;

  // One extra signed bit so -1 and GRID_W are visible.
  always_comb begin
    sx = signed'({1'b0, cur_x});
    sy = signed'({1'b0, cur_y});
    unique case (dir)
      DIR_UP:    sy = sy - ONE;
      DIR_RIGHT: sx = sx + ONE;
      DIR_DOWN:  sy = sy + ONE;
      DIR_LEFT:  sx = sx - ONE;
    endcase
`ifdef SNAKE_WRAP_EN
    oob = 1'b0;
    if (sx[COORD_W])   sx = GW - ONE;
    else if (sx >= GW) sx = '0;
    if (sy[COORD_W])   sy = GH - ONE;
    else if (sy >= GH) sy = '0;
`else
    oob = sx[COORD_W] || (sx >= GW) ||
          sy[COORD_W] || (sy >= GH);
`endif
    nxt_x = sx[COORD_W-1:0];
    nxt_y = sy[COORD_W-1:0];
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Per-tick snake move: latch dir, step head, scan body for
// self-hit, commit push. Edge wrap selected by SNAKE_WRAP_EN.
module snake_step_ctrl
  import snake_step_ctrl_pkg::*;
#(
  parameter int GRID_W   = GRID_W_D,
  parameter int GRID_H   = GRID_H_D,
  parameter int COORD_W  = COORD_W_D,
  parameter int MAX_LEN  = MAX_LEN_D,
  parameter int LEN_W    = LEN_W_D,
  parameter int INIT_LEN = INIT_LEN_D
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               restart,
  input  logic [1:0]         dir_in,
  input  logic               dir_valid,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  snake_step_ctrl_if.master  body,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   length,
  output logic               food_eaten,
  output logic               game_over,
  output logic               busy
);

  localparam logic [COORD_W-1:0] X0 =
    COORD_W'(GRID_W / 2);
  localparam logic [COORD_W-1:0] Y0 =
    COORD_W'(GRID_H / 2);
  localparam logic [LEN_W-1:0] LEN0 =
    LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LMAX =
    LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] L1 = LEN_W'(1);

  state_e             state;
  dir_e               dir;
  dir_e               pend_dir;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;
  logic [COORD_W-1:0] calc_x;
  logic [COORD_W-1:0] calc_y;
  logic               calc_oob;
  logic               calc_eat;
  logic               eat;
  logic               first;
  logic               hit;
  logic               last;
  logic               can_grow;
  logic [LEN_W-1:0]   lim;
  logic [LEN_W-1:0]   cmp_idx;

  snake_next_head #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .COORD_W (COORD_W)
  ) u_next (
    .cur_x (head_x),
    .cur_y (head_y),
    .dir   (dir),
    .nxt_x (calc_x),
    .nxt_y (calc_y),
    .oob   (calc_oob)
  );

  assign calc_eat = (calc_x == food_x) &&
                    (calc_y == food_y);
  assign hit      = (body.seg_x == nx) &&
                    (body.seg_y == ny);
  assign last     = (cmp_idx == lim - L1);
  assign can_grow = eat && (length < LMAX);

  // Pending direction: last non-reversing request wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dir <= DIR_RIGHT;
    end else if (restart) begin
      pend_dir <= DIR_RIGHT;
    end else if (dir_valid &&
                 !is_reverse(dir_e'(dir_in), dir)) begin
      pend_dir <= dir_e'(dir_in);
    end
  end

  // Move sequencer with registered store and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      dir           <= DIR_RIGHT;
      head_x        <= X0;
      head_y        <= Y0;
      length        <= LEN0;
      nx            <= '0;
      ny            <= '0;
      eat           <= 1'b0;
      lim           <= '0;
      cmp_idx       <= '0;
      first         <= 1'b0;
      body.seg_idx  <= '0;
      body.push     <= 1'b0;
      body.push_x   <= '0;
      body.push_y   <= '0;
      body.grow     <= 1'b0;
      body.body_clr <= 1'b0;
      food_eaten    <= 1'b0;
      game_over     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      body.push     <= 1'b0;
      body.grow     <= 1'b0;
      body.body_clr <= 1'b0;
      food_eaten    <= 1'b0;
      if (restart) begin
        state         <= ST_IDLE;
        dir           <= DIR_RIGHT;
        head_x        <= X0;
        head_y        <= Y0;
        length        <= LEN0;
        eat           <= 1'b0;
        first         <= 1'b0;
        cmp_idx       <= '0;
        body.seg_idx  <= '0;
        body.body_clr <= 1'b1;
        game_over     <= 1'b0;
        busy          <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (tick) begin
              dir   <= pend_dir;
              busy  <= 1'b1;
              state <= ST_CALC;
            end
          end
          ST_CALC: begin
            if (calc_oob) begin
              game_over <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_OVER;
            end else begin
              nx           <= calc_x;
              ny           <= calc_y;
              eat          <= calc_eat;
              lim          <= calc_eat ? length
                                       : length - L1;
              body.seg_idx <= '0;
              first        <= 1'b1;
              state        <= ST_SCAN;
            end
          end
          ST_SCAN: begin
            if (!first && hit) begin
              game_over <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_OVER;
            end else if ((lim == '0) ||
                         (!first && last)) begin
              body.push   <= 1'b1;
              body.push_x <= nx;
              body.push_y <= ny;
              body.grow   <= can_grow;
              food_eaten  <= eat;
              head_x      <= nx;
              head_y      <= ny;
              if (can_grow) length <= length + L1;
              state       <= ST_COMMIT;
            end else begin
              first   <= 1'b0;
              cmp_idx <= body.seg_idx;
              if (body.seg_idx + L1 < lim)
                body.seg_idx <= body.seg_idx + L1;
            end
          end
          ST_COMMIT: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          ST_OVER: begin
            game_over <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
